// File: rtl/frame_deframer_pkg.sv
// deframer_pkg: shared types and constants for the frame deframer.
//   state_t      - parser states HUNT, LEN, PAYLOAD, CHECK
//   SYNC_DEFAULT - default sync byte (8'hA5)
//   BYTE_W       - byte width
//   fifo_entry_t - output FIFO entry {last, data}
package deframer_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/frame_deframer_if.sv
// frame_deframer_if: bit input, payload byte stream and status of the deframer.
//   bit_valid/bit_in : recovered bit strobe and value (MSB first)
//   out_valid/out_ready/out_data/out_last : payload byte stream
//   frame_done/frame_ok/len_err : one-cycle status pulses
//   overflow  : sticky "payload byte dropped" flag
//   state_dbg : current parser state
//
// Handshake: a byte transfers on every cycle where out_valid & out_ready are
// both high at the rising clock edge. While out_valid is high and out_ready is
// low, out_data/out_last hold their value; out_valid never drops without a
// transfer except on reset.
interface frame_deframer_if;
    import deframer_pkg::*;

    logic                bit_valid;
    logic                bit_in;
    logic                out_valid;
    logic [BYTE_W-1:0]   out_data;
    logic                out_last;
    logic                out_ready;
    logic                frame_done;
    logic                frame_ok;
    logic                len_err;
    logic                overflow;
    state_t              state_dbg;

    // Deframer side.
    modport master (
        input  bit_valid, bit_in, out_ready,
        output out_valid, out_data, out_last,
        output frame_done, frame_ok, len_err, overflow, state_dbg
    );

    // Bit source / byte consumer side.
    modport slave (
        output bit_valid, bit_in, out_ready,
        input  out_valid, out_data, out_last,
        input  frame_done, frame_ok, len_err, overflow, state_dbg
    );
endinterface

// File: rtl/frame_deframer_byte_fifo.sv
// byte_fifo: synchronous FIFO of {last, data} entries.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data when not full (ignored when full)
//   full      : count == DEPTH
//   pop       : drop the head entry when not empty
//   empty     : count == 0
//   head      : head entry; all-zero when empty
// Fullness is judged on the registered count, so a pop in the same cycle
// does not make room for a push into a full FIFO.
module byte_fifo
    import deframer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t push_data,
    output logic        full,
    input  logic        pop,
    output logic        empty,
    output fifo_entry_t head
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/frame_deframer.sv
// frame_deframer: hunts for a sync byte in a recovered bit stream, then parses
// LEN, LEN payload bytes and an XOR checksum byte. Payload bytes leave through
// byte_fifo; per-frame status is pulsed on frame_done/frame_ok/len_err.
//   clk, rst : clock, synchronous active-high reset
//   bus      : frame_deframer_if.master (bit input, byte stream, status)
module frame_deframer
    import deframer_pkg::*;
#(
    parameter logic [7:0] SYNC       = SYNC_DEFAULT,
    parameter int         MAX_LEN    = 16,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    frame_deframer_if.master   bus
);
    localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

    state_t             state;
    logic [BYTE_W-1:0]  sr;
    logic [BYTE_W-1:0]  sr_next;
    logic [2:0]         bit_cnt;
    logic [BYTE_W-1:0]  csum;
    logic [BYTE_W-1:0]  remaining;
    logic               drop_flag;
    logic               frame_done_q;
    logic               frame_ok_q;
    logic               len_err_q;
    logic               overflow_q;

    logic               byte_done;
    logic               len_bad;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    fifo_entry_t        fifo_in;
    fifo_entry_t        fifo_head;

    // sr_next is the byte as it stands after the current bit is shifted in;
    // all byte decisions are taken on it so they land on the completing edge.
    assign sr_next   = {sr[BYTE_W-2:0], bus.bit_in};
    assign byte_done = bus.bit_valid && (bit_cnt == 3'd7);
    assign len_bad   = (sr_next == '0) || (sr_next > MAX_LEN_B);
    assign fifo_push = (state == PAYLOAD) && byte_done;
    assign fifo_in   = '{last: (remaining == BYTE_W'(1)), data: sr_next};

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_in),
        .full      (fifo_full),
        .pop       (bus.out_ready),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            sr           <= '0;
            bit_cnt      <= '0;
            csum         <= '0;
            remaining    <= '0;
            drop_flag    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            len_err_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            len_err_q    <= 1'b0;

            if (bus.bit_valid) begin
                sr      <= sr_next;
                bit_cnt <= bit_cnt + 3'd1;
            end

            case (state)
                HUNT: begin
                    if (bus.bit_valid && (sr_next == SYNC)) begin
                        state     <= LEN;
                        bit_cnt   <= '0;
                        drop_flag <= 1'b0;
                    end
                end
                LEN: begin
                    if (byte_done) begin
                        csum <= sr_next;
                        if (len_bad) begin
                            len_err_q <= 1'b1;
                            state     <= HUNT;
                        end else begin
                            remaining <= sr_next;
                            state     <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byte_done) begin
                        csum      <= csum ^ sr_next;
                        remaining <= remaining - BYTE_W'(1);
                        // A dropped byte is lost for good; parsing carries on
                        // so the checksum byte still lines up.
                        if (fifo_full) begin
                            overflow_q <= 1'b1;
                            drop_flag  <= 1'b1;
                        end
                        if (remaining == BYTE_W'(1)) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (byte_done) begin
                        frame_done_q <= 1'b1;
                        frame_ok_q   <= (sr_next == csum) && !drop_flag;
                        state        <= HUNT;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = fifo_head.data;
    assign bus.out_last   = fifo_head.last;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_ok   = frame_ok_q;
    assign bus.len_err    = len_err_q;
    assign bus.overflow   = overflow_q;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_frame_deframer.sv
// Testbench for frame_deframer. Frames are built at byte level; the expected
// payload bytes and frame status are derived from the frame contents (XOR
// checksum, length limits, FIFO capacity while the consumer stalls) and
// queued when the frame is issued. A negedge monitor compares the stream
// head and status pulses against those queues.
module tb_frame_deframer;
    import deframer_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_deframer_if bus ();

    frame_deframer #(
        .SYNC       (8'hA5),
        .MAX_LEN    (MAX_LEN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [8:0] exp_q[$];     // {last, data}
    logic [2:0] stat_q[$];    // {frame_done, frame_ok, len_err}
    int checks = 0;
    int errors = 0;
    bit bp_mode = 1'b0;       // consumer stalled: FIFO fills, excess dropped
    int held    = 0;          // bytes sitting in the FIFO while stalled

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got %0h expected no byte", {bus.out_last, bus.out_data});
                end else begin
                    chk("out_byte", {7'd0, bus.out_last, bus.out_data}, {7'd0, exp_q[0]});
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            if (bus.frame_done || bus.len_err) begin
                if (stat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL status_unexpected: got %0b expected no pulse",
                             {bus.frame_done, bus.frame_ok, bus.len_err});
                end else begin
                    chk("status", {13'd0, bus.frame_done, bus.frame_ok, bus.len_err}, {13'd0, stat_q[0]});
                    void'(stat_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves bit_valid high so consecutive gap-0 bits are back to back.
    task automatic send_bit(input logic b, input int gap);
        if (gap > 0) begin
            bus.bit_valid = 1'b0;
            repeat (gap) step();
        end
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        step();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
    endtask

    task automatic idle(input int n);
        bus.bit_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        bus.bit_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_out_valid",  16'(bus.out_valid), 16'd0);
        chk("rst_out_data",   16'(bus.out_data), 16'd0);
        chk("rst_out_last",   16'(bus.out_last), 16'd0);
        chk("rst_frame_done", 16'(bus.frame_done), 16'd0);
        chk("rst_frame_ok",   16'(bus.frame_ok), 16'd0);
        chk("rst_len_err",    16'(bus.len_err), 16'd0);
        chk("rst_overflow",   16'(bus.overflow), 16'd0);
        chk("rst_state",      16'(bus.state_dbg), 16'(HUNT));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || stat_q.size() != 0); i++) step();
        chk("drain", 16'(exp_q.size() + stat_q.size()), 16'd0);
    endtask

    // Eight zero bits, then optional noise, then the frame. The noise is
    // redrawn until no 8-bit window before the real sync equals A5.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$],
                              input logic [7:0] ck, input int gap, input int noise_n);
        logic [7:0] x;
        logic [7:0] w;
        logic [7:0] sync_b;
        bit dropped;
        bit bad;
        bit ok;
        bit nz[$];

        sync_b = 8'hA5;
        bad = (len == 8'd0) || (len > 8'(MAX_LEN));
        x = len;
        dropped = 1'b0;
        if (bad) begin
            stat_q.push_back(3'b001);
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                x ^= pl[i];
                if (bp_mode && held >= DEPTH) begin
                    dropped = 1'b1;
                end else begin
                    exp_q.push_back({(i == int'(len) - 1), pl[i]});
                    if (bp_mode) held++;
                end
            end
            stat_q.push_back({1'b1, (x == ck) && !dropped, 1'b0});
        end

        do begin
            nz.delete();
            repeat (noise_n) nz.push_back(1'($urandom_range(0, 1)));
            ok = 1'b1;
            w = 8'h00;
            foreach (nz[i]) begin
                w = {w[6:0], nz[i]};
                if (w == 8'hA5) ok = 1'b0;
            end
            for (int i = 7; i >= 1; i--) begin
                w = {w[6:0], sync_b[i]};
                if (w == 8'hA5) ok = 1'b0;
            end
        end while (!ok);

        send_byte(8'h00, gap);
        foreach (nz[i]) send_bit(nz[i], gap);
        send_byte(sync_b, gap);
        chk("sync_lock", 16'(bus.state_dbg), 16'(LEN));
        send_byte(len, gap);
        if (bad) begin
            chk("len_err_timing", 16'(bus.len_err), 16'd1);
            idle(1);
            return;
        end
        for (int i = 0; i < int'(len); i++) send_byte(pl[i], gap);
        send_byte(ck, gap);
        chk("done_timing", 16'(bus.frame_done), 16'd1);
        idle(1);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] len, input logic [7:0] pl[$]);
        logic [7:0] x = len;
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pl[$];
        logic [7:0] len;
        logic [7:0] ck;

        rst           = 1'b1;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.out_ready = 1'b1;
        do_reset();

        // good frame
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(8'd3, pl, 8'h03, 3, 0);
        // bad checksum
        send_frame(8'd3, pl, 8'h00, 3, 0);
        // length errors, then a good frame
        pl.delete();
        send_frame(8'd0, pl, 8'h00, 3, 0);
        send_frame(8'h11, pl, 8'h00, 3, 0);
        pl = '{8'h5A, 8'hC3};
        send_frame(8'd2, pl, xsum(8'd2, pl), 1, 0);
        // maximum length frame
        pl.delete();
        repeat (MAX_LEN) pl.push_back(8'($urandom));
        send_frame(8'(MAX_LEN), pl, xsum(8'(MAX_LEN), pl), 0, 0);
        wait_drain();

        // hunt alignment with noise, back-to-back bits, A5 inside payload
        for (int f = 0; f < 6; f++) begin
            len = 8'($urandom_range(1, MAX_LEN));
            pl.delete();
            repeat (int'(len)) pl.push_back(8'($urandom));
            pl[$urandom_range(0, int'(len) - 1)] = 8'hA5;
            ck = xsum(len, pl);
            if ($urandom_range(0, 3) == 0) ck = 8'($urandom);
            send_frame(len, pl, ck, 0, int'($urandom_range(0, 20)));
        end
        wait_drain();

        // backpressure: LEN 6 into a 4-deep FIFO with the consumer stalled
        bus.out_ready = 1'b0;
        bp_mode = 1'b1;
        held = 0;
        pl.delete();
        repeat (6) pl.push_back(8'($urandom));
        send_frame(8'd6, pl, xsum(8'd6, pl), 0, 0);
        idle(5);
        chk("bp_overflow", 16'(bus.overflow), 16'd1);
        chk("bp_held", 16'(exp_q.size()), 16'd4);
        bus.out_ready = 1'b1;
        bp_mode = 1'b0;
        held = 0;
        wait_drain();
        chk("bp_overflow_sticky", 16'(bus.overflow), 16'd1);
        chk("bp_drained", 16'(bus.out_valid), 16'd0);
        do_reset();

        // reset mid-payload after 2 of 5 bytes
        bus.out_ready = 1'b0;
        pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        exp_q.push_back({1'b0, pl[0]});
        exp_q.push_back({1'b0, pl[1]});
        send_byte(8'h00, 1);
        send_byte(8'hA5, 1);
        send_byte(8'd5, 1);
        send_byte(pl[0], 1);
        send_byte(pl[1], 1);
        idle(2);
        chk("mid_held", 16'(bus.out_valid), 16'd1);
        exp_q.delete();
        do_reset();
        bus.out_ready = 1'b1;
        idle(3);
        send_frame(8'd5, pl, xsum(8'd5, pl), 2, 0);
        wait_drain();

        idle(20);
        chk("final_exp_empty",  16'(exp_q.size()), 16'd0);
        chk("final_stat_empty", 16'(stat_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no end of stimulus expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/frame_deframer.md
# frame_deframer

Bit-to-frame stage directly downstream of the oversampling data recovery block. Consumes its one-cycle `bit_valid`/`bit_in` strobes, hunts for a sync byte, then assembles a length-prefixed, XOR-checksummed frame into bytes. Payload bytes go out through a small FIFO with a valid/ready handshake; per-frame status is reported as one-cycle pulses.

## Interface
- `SYNC`, 8'hA5: sync byte marking frame start.
- `MAX_LEN`, 16: largest legal LEN value; larger LEN is a length error.
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `bit_valid` in 1: one recovered bit present this cycle; may assert every cycle.
- `bit_in` in 1: recovered bit, MSB first within each byte.
- `out_valid` out 1: FIFO head holds a payload byte.
- `out_data` out 8: payload byte at FIFO head.
- `out_last` out 1: head byte is the last payload byte of its frame.
- `out_ready` in 1: consumer accepts head when `out_valid & out_ready`.
- `frame_done` out 1: one-cycle pulse when a frame's checksum byte completes.
- `frame_ok` out 1: qualifies `frame_done`; 1 = checksum matched and no overflow.
- `len_err` out 1: one-cycle pulse when LEN = 0 or LEN > `MAX_LEN`.
- `overflow` out 1: sticky; set when a payload byte is dropped because the FIFO is full; cleared only by `rst`.

## Operation
- 8-bit shift register `sr` shifts `{sr[6:0], bit_in}` on every `bit_valid`, in every state.
- 3-bit counter `bit_cnt` counts bits within the current byte; reset to 0 on sync match; a byte completes on the `bit_valid` where `bit_cnt == 7` (wraps to 0).
- States:
  - HUNT: the shifted value is compared on each `bit_valid`; match with `SYNC` → LEN, `bit_cnt` ← 0.
  - LEN: on byte completion latch `len`, `csum` ← byte. If byte = 0 or byte > `MAX_LEN`, pulse `len_err` → HUNT. Otherwise `remaining` ← byte → PAYLOAD.
  - PAYLOAD: on each byte completion `csum` ^= byte; push `{last = (remaining == 1), byte}` into the FIFO; decrement `remaining`; at `remaining == 1` → CHECK.
  - CHECK: on byte completion pulse `frame_done`, `frame_ok = (byte == csum) & ~drop_flag` → HUNT.
- Checksum: 8-bit XOR of LEN and all payload bytes.
- FIFO push only when count < `FIFO_DEPTH`; a same-cycle pop does not free space for the push. On a rejected push: set `overflow` and the per-frame `drop_flag` (cleared on LEN entry), and keep parsing the frame.
- Dropped bytes are never retried. If the dropped byte was the last one, no entry carries `out_last` for that frame.
- The FIFO output is registered-state driven. `out_data`/`out_last` are held stable while `out_valid & ~out_ready`.
- No resync inside a frame: `SYNC` values inside LEN/PAYLOAD/CHECK are data.

## Timing
- Reset values: state HUNT, `sr`=0, `bit_cnt`=0, `csum`=0, FIFO empty, `out_valid`=0, `out_data`=0, `out_last`=0, `frame_done`=0, `frame_ok`=0, `len_err`=0, `overflow`=0.
- `rst` mid-frame discards partial state and all FIFO contents in the next cycle; no `frame_done` is issued.
- Sync detect: state becomes LEN the cycle after the `bit_valid` carrying the sync's last bit.
- Byte push: the FIFO entry is visible (`out_valid`=1 if previously empty) the cycle after the completing `bit_valid`.
- `frame_done`/`frame_ok`/`len_err` assert the cycle after the completing `bit_valid`, for exactly one cycle.
- Simultaneous push and pop with count < `FIFO_DEPTH`: both occur and count is unchanged.
- Back-to-back frames: HUNT resumes on the cycle after CHECK. A sync immediately following the checksum is detected only once 8 new bits have been shifted in.

## Structure
- `deframer_pkg`: state enum (HUNT, LEN, PAYLOAD, CHECK), `SYNC_DEFAULT` = 8'hA5, byte width constant, FIFO entry struct `{last, data}`.
- Sub-module `byte_fifo`: parameterised synchronous FIFO with push/full/pop/empty and the count rule above. The deframer FSM and shift logic live in `frame_deframer`.

## Test plan
- Good frame: bits A5, 03, 11, 22, 33, csum 03^11^22^33 = 03, `bit_valid` every 4th cycle, `out_ready`=1 → out bytes 11, 22, 33 with `out_last` on 33; `frame_done`=1, `frame_ok`=1.
- Bad checksum: same frame with check byte 00 → same three bytes out; `frame_done`=1, `frame_ok`=0.
- Length error: A5, 00 → `len_err` pulse, no FIFO push. Then A5, 11 (17 > 16) → `len_err`. Then a good frame parses normally.
- Backpressure: `out_ready`=0, frame with LEN 6 into depth 4 → 4 bytes held; `overflow`=1 stays set; `frame_ok`=0. After `out_ready`=1 the first four bytes drain unchanged.
- Hunt alignment: random noise bits then A5 at an arbitrary bit offset, `bit_valid` every cycle → locks exactly on sync; payload containing A5 is output as data.
- Reset mid-PAYLOAD after 2 of 5 bytes → FIFO empty, `out_valid`=0 next cycle, no `frame_done`; next full frame parses with `frame_ok`=1.
